// File: rtl/wish_pack.sv
`default_nettype none
// ============================================================================
// Module   : wish_pack
// Brief    : Wishbone-style width packer, NUM_PACK source words per output word.
// Revision : 1.0 - initial release
// ============================================================================
module wish_pack #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  input  logic [DATA_WIDTH-1:0]          s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  input  logic                           d_ack_i,
  output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o
);

  localparam int c_idx_w = $clog2(NUM_PACK);
  localparam int c_pw    = DATA_WIDTH * NUM_PACK;
  localparam logic [c_idx_w-1:0] c_top_lane   = c_idx_w'(NUM_PACK - 1);
  localparam logic [c_idx_w-1:0] c_first_lane = (LITTLE_ENDIAN != 0) ? {c_idx_w{1'b0}} : c_top_lane;
  localparam logic [c_idx_w-1:0] c_last_lane  = (LITTLE_ENDIAN != 0) ? c_top_lane : {c_idx_w{1'b0}};

  logic [c_idx_w-1:0]   r_idx;
  logic [c_pw-1:0]      r_acc;
  logic [TGC_WIDTH-1:0] r_tgc_acc;
  logic                 r_d_stb;
  logic [c_pw-1:0]      r_d_dat;
  logic [TGC_WIDTH-1:0] r_d_tgc;

  logic                 w_stall;
  logic                 w_xfer;
  logic                 w_first;
  logic                 w_last;
  logic [c_idx_w-1:0]   w_idx_next;
  logic [c_pw-1:0]      w_acc_next;
  logic [TGC_WIDTH-1:0] w_tgc_next;

  // Stall only while a packed word is waiting and not being consumed this cycle.
  assign w_stall   = r_d_stb & ~d_ack_i;
  assign w_xfer    = s_stb_i & s_cyc_i & ~w_stall & rst_i;
  assign s_stall_o = w_stall;
  assign s_ack_o   = w_xfer;

  assign d_stb_o = r_d_stb;
  assign d_cyc_o = r_d_stb;
  assign d_dat_o = r_d_dat;
  assign d_tgc_o = r_d_tgc;

  assign w_first    = (r_idx == c_first_lane);
  assign w_last     = (r_idx == c_last_lane);
  assign w_tgc_next = w_first ? s_tgc_i : (r_tgc_acc | s_tgc_i);

  always_comb begin
    w_idx_next = r_idx;
    if (w_last)
      w_idx_next = c_first_lane;
    else if (LITTLE_ENDIAN != 0)
      w_idx_next = r_idx + c_idx_w'(1);
    else
      w_idx_next = r_idx - c_idx_w'(1);
  end

  generate
    for (genvar l = 0; l < NUM_PACK; l++) begin : g_lane
      localparam logic [c_idx_w-1:0] c_lane = c_idx_w'(l);
      assign w_acc_next[l*DATA_WIDTH +: DATA_WIDTH] =
        (r_idx == c_lane) ? s_dat_i : r_acc[l*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idx     <= c_first_lane;
      r_acc     <= '0;
      r_tgc_acc <= '0;
      r_d_stb   <= 1'b0;
      r_d_dat   <= '0;
      r_d_tgc   <= '0;
    end else begin
      if (w_xfer) begin
        r_idx     <= w_idx_next;
        r_acc     <= w_acc_next;
        r_tgc_acc <= w_tgc_next;
      end
      // A group completing on the ack edge replaces the consumed word directly.
      if (w_xfer && w_last) begin
        r_d_stb <= 1'b1;
        r_d_dat <= w_acc_next;
        r_d_tgc <= w_tgc_next;
      end else if (d_ack_i) begin
        r_d_stb <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wish_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_wish_pack
// Brief    : Directed plus random checks of wish_pack in both lane orders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wish_pack;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int TW = 2;
  localparam int PW = DW * NP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_stb, s_cyc, d_ack;
  logic [DW-1:0] s_dat;
  logic [TW-1:0] s_tgc;

  logic          le_s_ack, le_s_stall, le_d_stb, le_d_cyc;
  logic [PW-1:0] le_d_dat;
  logic [TW-1:0] le_d_tgc;
  logic          be_s_ack, be_s_stall, be_d_stb, be_d_cyc;
  logic [PW-1:0] be_d_dat;
  logic [TW-1:0] be_d_tgc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: words accepted in the current group, and the expected output register.
  logic [DW-1:0] q_dat[$];
  logic [TW-1:0] q_tgc[$];
  logic          exp_stb;
  logic [PW-1:0] exp_le, exp_be;
  logic [TW-1:0] exp_tgc;

  always #5 clk = ~clk;

  wish_pack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(1)) u_le (
    .clk_i(clk), .rst_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(le_s_ack),
    .s_stall_o(le_s_stall), .s_dat_i(s_dat), .s_tgc_i(s_tgc), .d_stb_o(le_d_stb),
    .d_cyc_o(le_d_cyc), .d_ack_i(d_ack), .d_dat_o(le_d_dat), .d_tgc_o(le_d_tgc)
  );

  wish_pack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(0)) u_be (
    .clk_i(clk), .rst_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(be_s_ack),
    .s_stall_o(be_s_stall), .s_dat_i(s_dat), .s_tgc_i(s_tgc), .d_stb_o(be_d_stb),
    .d_cyc_o(be_d_cyc), .d_ack_i(d_ack), .d_dat_o(be_d_dat), .d_tgc_o(be_d_tgc)
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input bit le);
    logic [PW-1:0] r = '0;
    for (int k = 0; k < NP; k++) begin
      int lane = le ? k : NP - 1 - k;
      r[lane*DW +: DW] = q_dat[k];
    end
    return r;
  endfunction

  task automatic model_reset();
    q_dat.delete();
    q_tgc.delete();
    exp_stb = 1'b0;
    exp_le  = '0;
    exp_be  = '0;
    exp_tgc = '0;
  endtask

  task automatic chk_outputs();
    chk("d_stb_le", PW'(le_d_stb), PW'(exp_stb));
    chk("d_cyc_le", PW'(le_d_cyc), PW'(exp_stb));
    chk("d_stb_be", PW'(be_d_stb), PW'(exp_stb));
    chk("d_cyc_be", PW'(be_d_cyc), PW'(exp_stb));
    chk("d_dat_le", le_d_dat, exp_le);
    chk("d_dat_be", be_d_dat, exp_be);
    chk("d_tgc_le", PW'(le_d_tgc), PW'(exp_tgc));
    chk("d_tgc_be", PW'(be_d_tgc), PW'(exp_tgc));
  endtask

  // One clock cycle: drive, check handshake, advance the model, check outputs.
  task automatic step(input logic stb, input logic cyc, input logic [DW-1:0] dat,
                      input logic [TW-1:0] tgc, input logic ack);
    logic exp_stall, exp_acc;
    logic [TW-1:0] t;
    @(negedge clk);
    s_stb = stb; s_cyc = cyc; s_dat = dat; s_tgc = tgc; d_ack = ack;
    #1;
    exp_stall = exp_stb & ~ack;
    exp_acc   = stb & cyc & ~exp_stall & rst_n;
    chk("s_ack_le",   PW'(le_s_ack),   PW'(exp_acc));
    chk("s_stall_le", PW'(le_s_stall), PW'(exp_stall));
    chk("s_ack_be",   PW'(be_s_ack),   PW'(exp_acc));
    chk("ack_stall_excl", PW'(le_s_ack & le_s_stall), PW'(1'b0));
    @(posedge clk);
    if (exp_acc) begin
      q_dat.push_back(dat);
      q_tgc.push_back(tgc);
    end
    if (exp_acc && q_dat.size() == NP) begin
      t = '0;
      foreach (q_tgc[k]) t |= q_tgc[k];
      exp_le  = pack(1'b1);
      exp_be  = pack(1'b0);
      exp_tgc = t;
      exp_stb = 1'b1;
      q_dat.delete();
      q_tgc.delete();
    end else if (ack) begin
      exp_stb = 1'b0;
    end
    #1;
    chk_outputs();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs();
    chk("s_ack_in_reset", PW'(le_s_ack), PW'(1'b0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    s_stb = 1'b0; s_cyc = 1'b0; d_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; s_stb = 1'b0; s_cyc = 1'b0; s_dat = '0; s_tgc = '0; d_ack = 1'b0;
    model_reset();
    #1;
    chk_outputs();
    step(1'b1, 1'b1, 8'h99, 2'd3, 1'b1);
    step(1'b1, 1'b1, 8'h98, 2'd3, 1'b1);
    release_reset();

    // Basic group in both lane orders, tags 0,1,0,2
    step(1'b1, 1'b1, 8'h11, 2'd0, 1'b1);
    step(1'b1, 1'b1, 8'h22, 2'd1, 1'b1);
    step(1'b1, 1'b1, 8'h33, 2'd0, 1'b1);
    step(1'b1, 1'b1, 8'h44, 2'd2, 1'b1);
    chk("le_word", le_d_dat, 32'h44332211);
    chk("be_word", be_d_dat, 32'h11223344);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b1);

    // Output held under back-pressure, then released with same-cycle accept
    step(1'b1, 1'b1, 8'h55, 2'd0, 1'b0);
    step(1'b1, 1'b1, 8'h66, 2'd0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 2'd0, 1'b0);
    step(1'b1, 1'b1, 8'h88, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hE0, 2'd2, 1'b0);
    step(1'b1, 1'b1, 8'h01, 2'd0, 1'b1);
    step(1'b1, 1'b0, 8'h02, 2'd3, 1'b1);
    step(1'b0, 1'b1, 8'h03, 2'd3, 1'b1);
    step(1'b1, 1'b1, 8'h02, 2'd0, 1'b1);
    step(1'b1, 1'b1, 8'h03, 2'd0, 1'b1);
    step(1'b1, 1'b1, 8'h04, 2'd0, 1'b1);
    chk("le_gap_word", le_d_dat, 32'h04030201);

    // Two groups back-to-back with no bubbles
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(8'h11 * (i + 1)), 2'(i), 1'b1);
    chk("le_second_word", le_d_dat, 32'h88776655);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b1);

    // Reset mid-group discards partial words
    step(1'b1, 1'b1, 8'h12, 2'd1, 1'b1);
    step(1'b1, 1'b1, 8'h34, 2'd1, 1'b1);
    async_reset();
    step(1'b1, 1'b1, 8'h56, 2'd1, 1'b1);
    release_reset();
    step(1'b1, 1'b1, 8'hAA, 2'd0, 1'b0);
    step(1'b1, 1'b1, 8'hBB, 2'd0, 1'b0);
    step(1'b1, 1'b1, 8'hCC, 2'd0, 1'b0);
    step(1'b1, 1'b1, 8'hDD, 2'd0, 1'b0);
    chk("le_after_reset", le_d_dat, 32'hDDCCBBAA);

    // Reset while a word is pending discards it
    async_reset();
    release_reset();

    // Idle gaps of three cycles between words
    for (int i = 0; i < NP; i++) begin
      step(1'b1, 1'b1, 8'(8'h11 * (i + 1)), 2'd0, 1'b1);
      for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 8'hFF, 2'd3, 1'b1);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
           8'($urandom), 2'($urandom), 1'($urandom_range(0, 2) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
